// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Holds the frame state encoding, prefix codes and the status-byte list.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam logic [7:0] PS2_BRK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;

    localparam int unsigned NUM_STATUS = 6;
    localparam logic [NUM_STATUS-1:0][7:0] PS2_STATUS = {
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF
    };

    // Keyboard status/ack bytes carry no key event and cancel pending prefixes.
    function automatic logic is_status(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(NUM_STATUS); i++) begin
            if (PS2_STATUS[i] == b) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronisers for the PS/2 pins plus falling-edge detect on the clock.
// Idle-high reset so a reset never fabricates an edge.
module ps2_sync_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic psClk,
    input  logic psData,
    output logic fall,
    output logic dat
);

    logic [1:0] r_clk_sync;
    logic [1:0] r_dat_sync;
    logic       r_clk_prev;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[0], psClk};
            r_dat_sync <= {r_dat_sync[0], psData};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    assign fall = r_clk_prev & ~r_clk_sync[1];
    assign dat  = r_dat_sync[1];

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: frame deserialiser with parity/framing/timeout checks,
// followed by an E0/F0 prefix folder that emits one key event per make or break.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       psClk,
    input  logic       psData,
    output logic [7:0] keyCode,
    output logic       ext,
    output logic       press,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

    logic w_fall;
    logic w_dat;

    ps2_sync_edge u_sync (
        .Clk    (Clk),
        .Reset  (Reset),
        .psClk  (psClk),
        .psData (psData),
        .fall   (w_fall),
        .dat    (w_dat)
    );

    frame_state_t  r_state,     w_state_n;
    logic [2:0]    r_cnt,       w_cnt_n;
    logic [7:0]    r_shift,     w_shift_n;
    logic          r_par,       w_par_n;
    logic [TW-1:0] r_tmo,       w_tmo_n;
    logic          r_brk,       w_brk_n;
    logic          r_extf,      w_extf_n;
    logic [7:0]    r_key_code,  w_key_code_n;
    logic          r_ext,       w_ext_n;
    logic          r_press,     w_press_n;
    logic          r_key_valid, w_key_valid_n;
    logic          r_frame_err, w_frame_err_n;
    logic          w_byte_ok;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_shift     <= 8'h00;
            r_par       <= 1'b0;
            r_tmo       <= '0;
            r_brk       <= 1'b0;
            r_extf      <= 1'b0;
            r_key_code  <= 8'h00;
            r_ext       <= 1'b0;
            r_press     <= 1'b0;
            r_key_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_shift     <= w_shift_n;
            r_par       <= w_par_n;
            r_tmo       <= w_tmo_n;
            r_brk       <= w_brk_n;
            r_extf      <= w_extf_n;
            r_key_code  <= w_key_code_n;
            r_ext       <= w_ext_n;
            r_press     <= w_press_n;
            r_key_valid <= w_key_valid_n;
            r_frame_err <= w_frame_err_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_shift_n     = r_shift;
        w_par_n       = r_par;
        w_tmo_n       = r_tmo;
        w_brk_n       = r_brk;
        w_extf_n      = r_extf;
        w_key_code_n  = r_key_code;
        w_ext_n       = r_ext;
        w_press_n     = r_press;
        w_key_valid_n = 1'b0;
        w_frame_err_n = 1'b0;
        w_byte_ok     = 1'b0;

        // Inter-edge watchdog: only runs while a frame is in flight, saturates at the limit.
        if (r_state == ST_IDLE || w_fall) begin
            w_tmo_n = '0;
        end else if (r_tmo != TMO_LIMIT) begin
            w_tmo_n = r_tmo + TW'(1);
        end

        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    if (!w_dat) begin
                        w_state_n = ST_DATA;
                        w_cnt_n   = 3'd0;
                    end else begin
                        w_frame_err_n = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_fall) begin
                    w_shift_n[r_cnt] = w_dat;
                    if (r_cnt == 3'd7) begin
                        w_state_n = ST_PARITY;
                    end else begin
                        w_cnt_n = r_cnt + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_fall) begin
                    w_par_n   = w_dat;
                    w_state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_fall) begin
                    w_state_n = ST_IDLE;
                    if (w_dat && (^{r_shift, r_par})) begin
                        w_byte_ok = 1'b1;
                    end else begin
                        w_frame_err_n = 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        if (r_state != ST_IDLE && !w_fall && r_tmo == TMO_LIMIT) begin
            w_frame_err_n = 1'b1;
            w_state_n     = ST_IDLE;
            w_tmo_n       = '0;
        end

        // Prefix folding: E0/F0 accumulate, status bytes cancel, anything else is a key.
        if (w_byte_ok) begin
            if (r_shift == PS2_BRK) begin
                w_brk_n = 1'b1;
            end else if (r_shift == PS2_EXT) begin
                w_extf_n = 1'b1;
            end else if (is_status(r_shift)) begin
                w_brk_n  = 1'b0;
                w_extf_n = 1'b0;
            end else begin
                w_key_code_n  = r_shift;
                w_ext_n       = r_extf;
                w_press_n     = ~r_brk;
                w_key_valid_n = 1'b1;
                w_brk_n       = 1'b0;
                w_extf_n      = 1'b0;
            end
        end

        if (w_frame_err_n) begin
            w_brk_n  = 1'b0;
            w_extf_n = 1'b0;
        end
    end

    assign keyCode   = r_key_code;
    assign ext       = r_ext;
    assign press     = r_press;
    assign key_valid = r_key_valid;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: byte-level decode model with an event queue,
// checked every cycle, plus literal expectations after key scenarios.
module tb_ps2_keycode_rx;

    localparam int unsigned TMO  = 200;
    localparam int          HALF = 40;

    logic       Clk    = 1'b0;
    logic       Reset  = 1'b1;
    logic       psClk  = 1'b1;
    logic       psData = 1'b1;
    logic [7:0] keyCode;
    logic       ext;
    logic       press;
    logic       key_valid;
    logic       frame_err;

    ps2_keycode_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .psClk     (psClk),
        .psData    (psData),
        .keyCode   (keyCode),
        .ext       (ext),
        .press     (press),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit         err;
        logic [7:0] code;
        bit         ext;
        bit         press;
        int         lmin;
        int         lmax;
    } ev_t;

    ev_t        q[$];
    int         cyc = 0;
    int         fall_cyc = 0;
    int         total = 0;
    int         bad = 0;
    logic [7:0] m_code = 8'h00;
    bit         m_ext = 1'b0;
    bit         m_press = 1'b0;
    bit         m_brk = 1'b0;
    bit         m_extf = 1'b0;
    bit         last_pulse = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic push_err(input int lmin, input int lmax);
        ev_t e;
        e.err = 1'b1; e.code = 8'h00; e.ext = 1'b0; e.press = 1'b0;
        e.lmin = lmin; e.lmax = lmax;
        q.push_back(e);
        m_brk  = 1'b0;
        m_extf = 1'b0;
    endtask

    // Byte-level decoder model: what one complete frame must produce.
    task automatic model_frame(input bit good, input logic [7:0] b);
        ev_t e;
        if (!good) begin
            push_err(2, 5);
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_extf = 1'b1;
        end else if (b == 8'h00 || b == 8'hAA || b == 8'hEE ||
                     b == 8'hFA || b == 8'hFE || b == 8'hFF) begin
            m_brk  = 1'b0;
            m_extf = 1'b0;
        end else begin
            e.err = 1'b0; e.code = b; e.ext = m_extf; e.press = !m_brk;
            e.lmin = 2; e.lmax = 5;
            q.push_back(e);
            m_brk  = 1'b0;
            m_extf = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            psData = bits[i];
            tick(HALF);
            psClk    = 1'b0;
            fall_cyc = cyc;
            tick(HALF);
            psClk = 1'b1;
        end
    endtask

    function automatic logic [10:0] mk_bits(input logic [7:0] b, input bit par_ok, input bit stop);
        logic par;
        par = (~^b) ^ !par_ok;
        return {stop, par, b, 1'b0};
    endfunction

    task automatic frame(input logic [7:0] b, input bit par_ok, input bit stop);
        model_frame(par_ok && stop, b);
        send_bits(mk_bits(b, par_ok, stop), 11);
        tick(HALF);
        check("event_missing", q.size(), 0);
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        m_code  = 8'h00;
        m_ext   = 1'b0;
        m_press = 1'b0;
        m_brk   = 1'b0;
        m_extf  = 1'b0;
        q.delete();
        tick(3);
        psClk  = 1'b1;
        psData = 1'b1;
        tick(1);
        Reset = 1'b0;
        tick(2);
    endtask

    // Every cycle: event legality/contents/latency against the queue, and output hold.
    always @(negedge Clk) begin
        if (!Reset) begin
            int  since;
            ev_t e;
            since = cyc - fall_cyc;
            if (key_valid && frame_err) check("pulse_overlap", 1, 0);
            if ((key_valid || frame_err) && last_pulse) check("pulse_width", 2, 1);
            if (key_valid || frame_err) begin
                if (q.size() == 0) begin
                    check("unexpected_event", {30'd0, key_valid, frame_err}, 0);
                end else begin
                    e = q.pop_front();
                    check("event_kind_err", frame_err, e.err);
                    total++;
                    if (since < e.lmin || since > e.lmax) begin
                        bad++;
                        $display("FAIL event_latency actual=%0d required=%0d..%0d", since, e.lmin, e.lmax);
                    end
                    if (!e.err) begin
                        m_code  = e.code;
                        m_ext   = e.ext;
                        m_press = e.press;
                    end
                end
            end
            check("hold_outputs", {keyCode, ext, press}, {m_code, m_ext, m_press});
            last_pulse = key_valid || frame_err;
        end else begin
            last_pulse = 1'b0;
        end
    end

    initial begin
        tick(4);
        Reset = 1'b0;
        tick(2);
        check("rst_keycode", keyCode, 8'h00);
        check("rst_flags", {ext, press, key_valid, frame_err}, 4'b0000);

        // make W
        frame(8'h1D, 1, 1);
        check("w_code", keyCode, 8'h1D);
        check("w_press_ext", {press, ext}, 2'b10);

        // plain break
        frame(8'hF0, 1, 1);
        frame(8'h1C, 1, 1);
        check("brk_code", keyCode, 8'h1C);
        check("brk_press", press, 1'b0);

        // extended make then extended break, both prefix orders
        frame(8'hE0, 1, 1);
        frame(8'h75, 1, 1);
        check("extmk", {keyCode, ext, press}, {8'h75, 2'b11});
        frame(8'hE0, 1, 1);
        frame(8'hF0, 1, 1);
        frame(8'h75, 1, 1);
        check("extbrk", {keyCode, ext, press}, {8'h75, 2'b10});
        frame(8'hF0, 1, 1);
        frame(8'hE0, 1, 1);
        frame(8'h6B, 1, 1);
        check("extbrk_swap", {keyCode, ext, press}, {8'h6B, 2'b10});

        // parity fault keeps outputs, next frame decodes
        frame(8'h1D, 0, 1);
        check("par_hold", {keyCode, ext, press}, {8'h6B, 2'b10});
        frame(8'h1C, 1, 1);
        check("par_recover", {keyCode, press}, {8'h1C, 1'b1});

        // typematic repeat
        frame(8'h1C, 1, 1);
        frame(8'h1C, 1, 1);
        check("typematic", {keyCode, press}, {8'h1C, 1'b1});

        // status byte cancels pending prefix
        frame(8'hE0, 1, 1);
        frame(8'hAA, 1, 1);
        frame(8'h1D, 1, 1);
        check("status_clr", {keyCode, ext, press}, {8'h1D, 2'b01});

        // bad stop bit clears a pending break
        frame(8'hF0, 1, 1);
        frame(8'h24, 1, 0);
        frame(8'h24, 1, 1);
        check("stop_clr", {keyCode, press}, {8'h24, 1'b1});

        // bad start bit
        push_err(2, 5);
        send_bits(11'h7FF, 1);
        tick(HALF);
        check("badstart_seen", q.size(), 0);

        // timeout after four edges
        push_err(int'(TMO), int'(TMO) + 10);
        send_bits(mk_bits(8'h1D, 1, 1), 4);
        tick(260);
        check("timeout_seen", q.size(), 0);
        frame(8'h1D, 1, 1);
        check("tmo_recover", {keyCode, ext, press}, {8'h1D, 2'b01});

        // reset during bit 5 of F0
        send_bits(mk_bits(8'hF0, 1, 1), 6);
        psData = 1'b1;
        tick(HALF);
        psClk = 1'b0;
        tick(10);
        do_reset();
        check("midrst_code", keyCode, 8'h00);
        frame(8'h1D, 1, 1);
        check("midrst_after", {keyCode, ext, press}, {8'h1D, 2'b01});

        tick(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_keycode_rx.md
# ps2_keycode_rx

PS/2 keyboard receiver and scancode decoder. It sits directly upstream of the sprite-motion logic and drives the `keyCode`/`press` pair that the motion block and the hex display consume. It deserialises 11-bit PS/2 frames from the raw `PS2_CLK`/`PS2_DAT` pins and checks framing and parity. It then folds the `E0`/`F0` prefixes into one decoded key event per make or break.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 10000: `Clk` cycles (200 µs at 50 MHz) allowed between PS/2 falling edges inside a frame before the frame is aborted.

Ports:
- `Clk`, input, 1: system clock, 50 MHz. This is the block's only clock.
- `Reset`, input, 1: synchronous, active-high reset.
- `psClk`, input, 1: raw PS/2 clock pin. Asynchronous to `Clk`.
- `psData`, input, 1: raw PS/2 data pin. Asynchronous to `Clk`.
- `keyCode`, output, 8: last decoded scancode, prefixes stripped.
- `ext`, output, 1: `keyCode` was preceded by `E0`.
- `press`, output, 1: level. 1 means the key in `keyCode` is held (make); 0 means it was released (break).
- `key_valid`, output, 1: one-cycle pulse when `keyCode`/`ext`/`press` update.
- `frame_err`, output, 1: one-cycle pulse on a bad start bit, parity error, bad stop bit or timeout.

## Operation
Input synchronisation and edge detection:
- `psClk` and `psData` each pass through two flip-flops.
- A falling edge is synchronised-previous = 1 and synchronised-current = 0.
- Data is sampled only in the edge cycle.

Frame FSM (`IDLE`, `DATA`, `PARITY`, `STOP`):
- `IDLE`: on an edge, if data = 0 go to `DATA` with bit count 0. If data = 1, pulse `frame_err` and stay in `IDLE`.
- `DATA`: each edge shifts data into bit `[count]`, LSB first. After the 8th bit go to `PARITY`.
- `PARITY`: store the bit. The frame is valid only if the XOR of the 8 data bits and the parity bit = 1 (odd parity).
- `STOP`: the stop bit must be 1. A good frame hands its byte to the decoder; a bad one pulses `frame_err`. Return to `IDLE` either way.
- Timeout counter: cleared on every edge and held at 0 in `IDLE`. In any other state, reaching `TIMEOUT_CYCLES` pulses `frame_err` and forces `IDLE`.

Byte decoder:
- `F0`: set the break flag and emit nothing.
- `E0`: set the ext flag and emit nothing.
- Status bytes `00`, `AA`, `EE`, `FA`, `FE`, `FF`: clear both flags and emit nothing.
- Any other byte: `keyCode` = byte, `ext` = ext flag, `press` = ~break flag. Pulse `key_valid` and clear both flags.
- Prefixes accumulate in any order (`E0 F0 xx` and `F0 E0 xx` both decode as an extended break).
- Any `frame_err` clears both flags.
- Typematic repeat (the same make repeated) emits `key_valid` each time; `press` stays 1.

## Timing
- Pin-to-edge-detect latency: 2–3 `Clk` cycles.
- `keyCode`/`ext`/`press` update and `key_valid` asserts in the cycle after the stop-bit edge-detect cycle.
- `frame_err` asserts in that same cycle for stop or parity faults. It asserts in the cycle after the start-bit edge for a bad start bit, and in the cycle after the counter reaches `TIMEOUT_CYCLES` for a timeout.
- `key_valid` and `frame_err` never assert together and are never longer than 1 cycle.
- Outputs hold between events. A bad frame leaves `keyCode`, `ext` and `press` unchanged.
- Reset, effective at the next `Clk` edge:
  - `keyCode` = 0x00, `ext` = 0, `press` = 0, `key_valid` = 0, `frame_err` = 0.
  - FSM in `IDLE`, bit count and timeout counter 0, flags cleared, synchronisers = 1.
- Reset mid-frame discards the partial frame; no error pulse is generated.
- The timeout counter is `$clog2(TIMEOUT_CYCLES+1)` bits wide and saturates rather than wrapping.

## Structure
- Package `ps2_pkg`:
  - frame state enum;
  - constants `PS2_BRK` = 8'hF0 and `PS2_EXT` = 8'hE0;
  - the status-byte list.
- Sub-module `ps2_sync_edge`: two-flop synchronisers for both pins plus falling-edge detect. Outputs `fall` and `dat`.
- The frame FSM and the byte decoder stay in the top module.

## Test plan
Bit period is 80 µs. Frames are listed as start, 8 data bits LSB first, parity, stop.
- Make 0x1D (`W`): frame 0,1011_1000,1,1 → one `key_valid` pulse; `keyCode` = 0x1D, `press` = 1, `ext` = 0.
- Break: `F0` (parity 1) then `1C` (parity 0) → one `key_valid` only, after `1C`; `keyCode` = 0x1C, `press` = 0.
- Extended make then break: `E0 75`, then `E0 F0 75` → two `key_valid` pulses, both with `ext` = 1 and `keyCode` = 0x75; `press` is 1 then 0.
- Parity fault: `1D` sent with parity 0 → `frame_err` pulses; outputs keep their prior values. A following good `1C` decodes normally.
- Timeout: 4 bits sent, then the clock stops for 250 µs → `frame_err` pulses near 200 µs. A fresh `1D` then decodes correctly.
- Reset during bit 5 of `F0`, then `1D` → `press` = 1, `keyCode` = 0x1D, no error pulse, and no stale break flag.
